// File: rtl/systolic_mm_ctrl.sv
// Sequencing controller for an N x N systolic matrix-multiply array: accepts a job,
// then loads, feeds, drains and presents the result over one or more K-tiles.
module systolic_mm_ctrl #(
  parameter int N      = 3,
  parameter int PE_LAT = 1,
  parameter int TW     = 8,
  parameter int SW     = $clog2(2*N-1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [TW-1:0] num_tiles,
  input  logic          tile_valid,
  output logic          tile_ready,
  output logic          load_en,
  output logic          acc_clr,
  output logic          feed_en,
  output logic [SW-1:0] feed_step,
  output logic [TW-1:0] tile_idx,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy
);

  localparam int DRAIN_CYC = N - 1 + PE_LAT;
  localparam int DW        = $clog2(DRAIN_CYC + 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(2*N - 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tiles_total_q, tiles_total_d;
  logic [TW-1:0] tile_idx_q, tile_idx_d;
  logic [SW-1:0] feed_step_q, feed_step_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          acc_clr_q, acc_clr_d;

  logic start_hs;
  logic load_hs;
  logic feed_last;
  logic drain_last;
  logic more_tiles;

  assign start_hs   = (state_q == S_IDLE) && start_valid;
  assign load_hs    = (state_q == S_LOAD) && tile_valid;
  assign feed_last  = (feed_step_q == STEP_LAST);
  assign drain_last = (drain_cnt_q == DRAIN_LAST);
  // tiles_total is never 0, so the subtraction cannot wrap.
  assign more_tiles = (tile_idx_q < (tiles_total_q - TW'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_valid) state_d = S_LOAD;
      S_LOAD:   if (tile_valid) state_d = S_FEED;
      S_FEED:   if (feed_last) state_d = more_tiles ? S_LOAD : S_DRAIN;
      S_DRAIN:  if (drain_last) state_d = S_RESULT;
      S_RESULT: if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Job bookkeeping: tile count, tile index, feeder step and drain counter.
  always_comb begin
    tiles_total_d = tiles_total_q;
    tile_idx_d    = tile_idx_q;
    feed_step_d   = feed_step_q;
    drain_cnt_d   = drain_cnt_q;
    acc_clr_d     = 1'b0;

    if (start_hs) begin
      tiles_total_d = (num_tiles == '0) ? TW'(1) : num_tiles;
      tile_idx_d    = '0;
      acc_clr_d     = 1'b1;
    end

    if (load_hs) begin
      feed_step_d = '0;
    end

    if (state_q == S_FEED) begin
      if (!feed_last) begin
        feed_step_d = feed_step_q + SW'(1);
      end else if (more_tiles) begin
        tile_idx_d = tile_idx_q + TW'(1);
      end else begin
        drain_cnt_d = '0;
      end
    end

    if ((state_q == S_DRAIN) && !drain_last) begin
      drain_cnt_d = drain_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tiles_total_q <= TW'(1);
      tile_idx_q    <= '0;
      feed_step_q   <= '0;
      drain_cnt_q   <= '0;
      acc_clr_q     <= 1'b0;
    end else begin
      tiles_total_q <= tiles_total_d;
      tile_idx_q    <= tile_idx_d;
      feed_step_q   <= feed_step_d;
      drain_cnt_q   <= drain_cnt_d;
      acc_clr_q     <= acc_clr_d;
    end
  end

  always_comb begin
    start_ready = 1'b0;
    tile_ready  = 1'b0;
    feed_en     = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      S_LOAD:   tile_ready = 1'b1;
      S_FEED:   feed_en    = 1'b1;
      S_DRAIN:  busy       = 1'b1;
      S_RESULT: res_valid  = 1'b1;
      default: begin
        start_ready = 1'b0;
        busy        = 1'b1;
      end
    endcase
  end

  // acc_clr is a one-cycle registered pulse, so a stalled first LOAD never repeats it.
  assign acc_clr   = acc_clr_q;
  assign load_en   = tile_valid & tile_ready;
  assign feed_step = feed_en ? feed_step_q : '0;
  assign tile_idx  = tile_idx_q;

endmodule

// File: doc/systolic_mm_ctrl.md
# systolic_mm_ctrl

Sequencing controller for the N×N systolic matrix-multiply datapath. It accepts a job command, then walks the datapath through one or more K-dimension operand tiles: load the operands, feed skewed rows and columns, drain the array, and present the result. It drives the operand-skew feeder (feed enable and step index), the PE accumulator clear, and the operand-register load strobe. It sits between the job-issuing host logic and the feeder/PE array.

## Interface
- N, default 3: array dimension (N×N PEs); N ≥ 2.
- PE_LAT, default 1: PE multiply-accumulate latency in cycles; ≥ 1.
- TW, default 8: width of the tile-count field.
- SW, default $clog2(2N-1): width of feed_step (3 for N=3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start_valid  in  1  job request.
- start_ready  out  1  controller idle and accepting a job.
- num_tiles  in  TW  number of K-tiles in the job, sampled on start handshake; 0 is treated as 1.
- tile_valid  in  1  next operand tile present at the operand registers' inputs.
- tile_ready  out  1  controller waiting for a tile.
- load_en  out  1  operand-register load strobe; equals tile_valid & tile_ready (combinational).
- acc_clr  out  1  clear all PE accumulators.
- feed_en  out  1  feeder active.
- feed_step  out  SW  feeder step index, 0..2N-2.
- tile_idx  out  TW  index of the tile currently loading or feeding.
- res_valid  out  1  PE accumulators hold the final result.
- res_ready  in  1  result consumed.
- busy  out  1  state ≠ IDLE.

## Operation
- The FSM has five states: IDLE, LOAD, FEED, DRAIN, RESULT.
- **IDLE**
  - start_ready=1.
  - On start_valid: latch tiles_total = max(num_tiles,1), set tile_idx=0, go to LOAD.
  - acc_clr=1 for exactly the next cycle, which is the first LOAD cycle.
- **LOAD**
  - tile_ready=1.
  - Waits indefinitely for tile_valid.
  - On load_en: feed_step←0, go to FEED.
  - acc_clr is never reasserted for later tiles, so accumulation spans all tiles.
- **FEED**
  - feed_en=1. feed_step increments by 1 each cycle.
  - When feed_step=2N-2, do not increment further. Then:
    - if tile_idx < tiles_total-1: tile_idx+1, go to LOAD;
    - else: drain counter←0, go to DRAIN.
- **DRAIN**
  - Counts DRAIN_CYC = N-1+PE_LAT cycles, then goes to RESULT.
- **RESULT**
  - res_valid=1, held until res_ready is high.
  - On res_valid & res_ready: go to IDLE.
  - The next job may be accepted one cycle later.
- Outputs not named in a state are 0. tile_idx holds its last value in DRAIN, RESULT and IDLE.
- start_valid is ignored outside IDLE. tile_valid is ignored outside LOAD.
- res_ready while not in RESULT has no effect.
- A start_valid and res_ready that coincide in RESULT complete the result only; the job is accepted the following cycle, in IDLE.
- num_tiles=2^TW-1 is supported without tile_idx overflow.

## Timing
- All outputs except load_en are registered or decoded from registered state.
- Reset (any cycle, including mid-FEED or mid-DRAIN): next state IDLE; tile_idx=0, feed_step=0, drain counter=0.
  - After reset: start_ready=1; tile_ready, acc_clr, feed_en, res_valid, busy = 0.
  - An aborted job leaves no residue and requires no result handshake.
- Single-tile latency with tile_valid already high and res_ready high, cycle 0 = start handshake:
  - cycle 1 = LOAD, with acc_clr and load_en;
  - cycles 2..2N = FEED;
  - DRAIN_CYC cycles of DRAIN;
  - res_valid first high at cycle 2N+1+DRAIN_CYC (10 for N=3, PE_LAT=1).
- Each additional tile adds 1+(2N-1) cycles plus any tile_valid stall.
- Throughput: one job per (latency + 1) cycles minimum.

## Test plan
- **Basic job, N=3, PE_LAT=1, num_tiles=1, tile_valid and res_ready tied high:**
  - start at cycle 0 → acc_clr and load_en at cycle 1;
  - feed_en cycles 2-6 with feed_step 0,1,2,3,4;
  - res_valid at cycle 10, busy low at cycle 11.
- **num_tiles=3:**
  - three load_en pulses; tile_idx 0,1,2;
  - acc_clr exactly once;
  - three 5-cycle feed bursts each restarting at step 0;
  - res_valid at cycle 22.
- **num_tiles=0:** behaves identically to num_tiles=1; a single feed burst.
- **Backpressure:**
  - tile_valid low for 4 cycles in LOAD → tile_ready held, feed_en stays 0, acc_clr not repeated;
  - res_ready low for 5 cycles → res_valid held, start_valid ignored.
- **Reset mid-FEED at feed_step=2:**
  - next cycle all outputs at reset values with start_ready=1;
  - a new job then runs with nominal timing.
- **Back-to-back jobs:** start_valid held high across RESULT → second job accepted exactly one cycle after the result handshake; tile_idx restarts at 0.
